// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bundle (req/addr_ok/data_ok handshake); no storage, no latency.
// Backpressure: req is held until addr_ok; data_ok/rdata beats cannot be stalled.
interface sram_bus_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave between inst and data masters; zero added latency on address and response paths.
// Backpressure: grant locks until slave addr_ok; sram_req is withheld while DEPTH transactions are outstanding.
module sram_bus_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    sram_bus_if.slave  inst_sram,
    sram_bus_if.slave  data_sram,
    sram_bus_if.master sram
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

    lock_state_t      lock_state;
    lock_state_t      lock_state_nxt;

    logic [DEPTH-1:0] owner_fifo;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic             has_owner;
    logic             owner;
    logic             owner_req;
    logic             full;
    logic             addr_hs;
    logic             pop;
    logic             head_owner;
    logic             starved;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign starved = (starve_cnt == SW'(STARVE_LIMIT));

    // owner: 0 = inst, 1 = data; a pending (locked) address phase always keeps its master
    always_comb begin
        has_owner = 1'b0;
        owner     = 1'b1;
        if (lock_state == LOCK_INST) begin
            has_owner = 1'b1;
            owner     = 1'b0;
        end else if (lock_state == LOCK_DATA) begin
            has_owner = 1'b1;
            owner     = 1'b1;
        end else if (inst_sram.req && data_sram.req) begin
            has_owner = 1'b1;
            owner     = !starved;
        end else if (inst_sram.req) begin
            has_owner = 1'b1;
            owner     = 1'b0;
        end else if (data_sram.req) begin
            has_owner = 1'b1;
            owner     = 1'b1;
        end
    end

    assign owner_req = has_owner && (owner ? data_sram.req : inst_sram.req);
    assign full      = (count == CW'(DEPTH));

    assign sram.req   = reset && owner_req && !full;
    assign sram.wr    = (has_owner && !owner) ? inst_sram.wr    : data_sram.wr;
    assign sram.size  = (has_owner && !owner) ? inst_sram.size  : data_sram.size;
    assign sram.wstrb = (has_owner && !owner) ? inst_sram.wstrb : data_sram.wstrb;
    assign sram.addr  = (has_owner && !owner) ? inst_sram.addr  : data_sram.addr;
    assign sram.wdata = (has_owner && !owner) ? inst_sram.wdata : data_sram.wdata;

    assign addr_hs           = sram.req && sram.addr_ok;
    assign inst_sram.addr_ok = addr_hs && !owner;
    assign data_sram.addr_ok = addr_hs && owner;

    // a beat with nothing outstanding is a slave protocol error and is dropped
    assign head_owner        = owner_fifo[rd_ptr];
    assign pop               = reset && sram.data_ok && (count != '0);
    assign inst_sram.data_ok = pop && !head_owner;
    assign data_sram.data_ok = pop && head_owner;
    assign inst_sram.rdata   = sram.rdata;
    assign data_sram.rdata   = sram.rdata;

    always_comb begin
        lock_state_nxt = lock_state;
        if (addr_hs) begin
            lock_state_nxt = UNLOCKED;
        end else if (sram.req) begin
            lock_state_nxt = owner ? LOCK_DATA : LOCK_INST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_fifo <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (addr_hs) begin
                owner_fifo[wr_ptr] <= owner;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(addr_hs) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!inst_sram.req || inst_sram.addr_ok) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized and directed bench for sram_bus_arbiter: queue-based reference model for grants,
// scoreboard of expected response beats checked by an independent monitor.
module tb_sram_bus_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    sram_bus_if inst_if ();
    sram_bus_if data_if ();
    sram_bus_if sram_if ();

    sram_bus_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .sram      (sram_if)
    );

    always #5 clk = ~clk;

    int checks_n = 0;
    int fails_n  = 0;

    // reference model state
    bit          pend[$];
    logic [32:0] sb[$];
    int          lock_to = -1;
    int          denied = 0;
    bit          i_hold = 1'b0;
    bit          d_hold = 1'b0;
    logic [70:0] i_bun = '0;
    logic [70:0] d_bun = '0;
    logic [31:0] i_addr_force = '0;
    bit          inst_aok_seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks_n++;
        if (act !== exp) begin
            fails_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_bundle(output logic [70:0] b);
        b[31:0]  = $urandom;
        b[63:32] = $urandom;
        b[70:64] = 7'($urandom);
    endtask

    task automatic drive_masters();
        inst_if.req = i_hold;
        data_if.req = d_hold;
        {inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.addr, inst_if.wdata} = i_bun;
        {data_if.wr, data_if.size, data_if.wstrb, data_if.addr, data_if.wdata} = d_bun;
    endtask

    // one bus cycle: called at posedge+1, returns at the next posedge+1
    task automatic step(input bit i_new, input bit d_new, input bit aok, input bit dok,
                        input logic [31:0] rd);
        int          own;
        bit          ereq;
        bit          hs;
        bit          popd;
        logic [70:0] ebun;
        logic [70:0] abun;
        if (i_new && !i_hold) begin
            new_bundle(i_bun);
            if (i_addr_force != '0) i_bun[63:32] = i_addr_force;
            i_hold = 1'b1;
        end
        if (d_new && !d_hold) begin
            new_bundle(d_bun);
            d_hold = 1'b1;
        end
        drive_masters();
        sram_if.addr_ok = aok;
        sram_if.data_ok = dok;
        sram_if.rdata   = rd;

        if (lock_to >= 0)          own = lock_to;
        else if (i_hold && d_hold) own = (denied >= LIMIT) ? 0 : 1;
        else if (i_hold)           own = 0;
        else if (d_hold)           own = 1;
        else                       own = -1;
        ereq = ((own == 0 && i_hold) || (own == 1 && d_hold)) && (pend.size() < DEPTH);
        hs   = ereq && aok;
        popd = dok && (pend.size() > 0);
        if (popd) sb.push_back({pend[0], rd});
        ebun = (own == 0) ? i_bun : d_bun;

        @(negedge clk);
        chk("sram_req", 128'(sram_if.req), 128'(ereq));
        chk("inst_addr_ok", 128'(inst_if.addr_ok), 128'(hs && own == 0));
        chk("data_addr_ok", 128'(data_if.addr_ok), 128'(hs && own == 1));
        abun = {sram_if.wr, sram_if.size, sram_if.wstrb, sram_if.addr, sram_if.wdata};
        chk("sram_bundle", 128'(abun), 128'(ebun));
        inst_aok_seen = inst_if.addr_ok;

        if (popd) void'(pend.pop_front());
        if (hs) begin
            pend.push_back(own == 1);
            lock_to = -1;
        end else if (ereq) begin
            lock_to = own;
        end
        if (i_hold && !(hs && own == 0)) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
        else                             denied = 0;

        @(posedge clk);
        #1;
        if (hs && own == 0) i_hold = 1'b0;
        if (hs && own == 1) d_hold = 1'b0;
        drive_masters();
        sram_if.data_ok = 1'b0;
    endtask

    // asynchronous reset in the middle of a cycle with live bus activity
    task automatic mid_reset();
        sram_if.addr_ok = 1'b1;
        sram_if.data_ok = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_sram_req", 128'(sram_if.req), 128'(0));
        chk("rst_addr_ok", 128'({inst_if.addr_ok, data_if.addr_ok}), 128'(0));
        chk("rst_data_ok", 128'({inst_if.data_ok, data_if.data_ok}), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        sram_if.data_ok = 1'b0;
        sram_if.addr_ok = 1'b0;
        pend.delete();
        lock_to = -1;
        denied  = 0;
    endtask

    // response monitor: every routed beat must match the head of the scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (inst_if.data_ok || data_if.data_ok) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 128'({inst_if.data_ok, data_if.data_ok}), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("resp_route", 128'({inst_if.data_ok, data_if.data_ok}),
                    128'(e[32] ? 2'b01 : 2'b10));
                chk("resp_rdata", 128'(e[32] ? data_if.rdata : inst_if.rdata), 128'(e[31:0]));
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_missing", 128'({inst_if.data_ok, data_if.data_ok}),
                128'(e[32] ? 2'b01 : 2'b10));
        end
    end

    initial begin
        int first;
        drive_masters();
        inst_if.req     = 1'b1;
        data_if.req     = 1'b1;
        sram_if.addr_ok = 1'b1;
        sram_if.data_ok = 1'b1;
        sram_if.rdata   = 32'h0;
        #3;
        chk("init_sram_req", 128'(sram_if.req), 128'(0));
        chk("init_addr_ok", 128'({inst_if.addr_ok, data_if.addr_ok}), 128'(0));
        chk("init_data_ok", 128'({inst_if.data_ok, data_if.data_ok}), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        drive_masters();
        sram_if.addr_ok = 1'b0;
        sram_if.data_ok = 1'b0;
        reset = 1'b1;

        // single inst fetch, response three cycles after acceptance
        i_addr_force = 32'h1FC0_0000;
        step(1, 0, 1, 0, 32'h0);
        chk("fetch_addr_ok", 128'(inst_aok_seen), 128'(1));
        i_addr_force = '0;
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h2408_0001);

        // simultaneous requests: data first, inst next cycle, responses in order
        step(1, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 0, 1, $urandom);

        // slave stalls a locked data grant for four cycles
        repeat (4) step(1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 0, 1, $urandom);

        // outstanding limit reached, then drained with overlapping accept
        step(1, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 1, $urandom);
        step(0, 0, 1, 1, $urandom);
        step(0, 0, 0, 1, $urandom);

        // continuous data traffic starves inst until the limit forces its grant
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, 1, 1, $urandom);
            if (inst_aok_seen && first == 0) first = k;
        end
        chk("starve_grant_cycle", 128'(first), 128'(LIMIT + 1));
        repeat (3) step(0, 0, 1, 1, $urandom);
        repeat (3) step(0, 0, 0, 1, $urandom);

        // stray beat on an empty queue, then reset with two outstanding
        step(0, 0, 0, 1, $urandom);
        step(1, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        mid_reset();
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) mid_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), $urandom);
        end
        repeat (4) step(0, 0, 1, 1, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one SRAM-like bus (req/addr_ok/data_ok handshake) between the instruction-fetch port (driven by the instruction cache on a miss) and the data port (load/store unit). It arbitrates each address phase, holds a grant stable until the slave accepts it, and tracks outstanding transactions in order. Each `data_ok`/`rdata` beat is routed back to the master that issued it. It sits between the CPU-side caches and the single external SRAM-like slave.

## Interface
- `DEPTH`, 2: maximum outstanding accepted-but-unanswered transactions; power of 2, ≥1.
- `STARVE_LIMIT`, 8: consecutive cycles of denied inst requests after which inst beats data priority; ≥1.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `inst_sram_{req,wr,size,wstrb,addr,wdata}` input 1/1/2/4/32/32: fetch-side request bundle.
- `inst_sram_{addr_ok,data_ok}` output 1/1: fetch-side handshakes.
- `inst_sram_rdata` output 32: fetch-side read data.
- `data_sram_{req,wr,size,wstrb,addr,wdata}` input 1/1/2/4/32/32: data-side request bundle.
- `data_sram_{addr_ok,data_ok}` output 1/1: data-side handshakes.
- `data_sram_rdata` output 32: data-side read data.
- `sram_{req,wr,size,wstrb,addr,wdata}` output 1/1/2/4/32/32: request bundle to the slave.
- `sram_{addr_ok,data_ok}` input 1/1: slave handshakes.
- `sram_rdata` input 32: slave read data.

## Operation
- State:
  - `lock_valid`, `lock_owner` (0=inst, 1=data).
  - Owner FIFO of `DEPTH` 1-bit entries, with `count` of width clog2(DEPTH)+1.
  - `starve_cnt`, saturating at `STARVE_LIMIT`.
- Owner selection, combinational, each cycle:
  - If `lock_valid`: owner = `lock_owner`.
  - Else, if both request: data wins unless `starve_cnt == STARVE_LIMIT`, in which case inst wins.
  - Else, if one requests: that master.
  - Else: no owner.
- Slave request:
  - `sram_req` = owner's req AND `count != DEPTH`.
  - `sram_wr/size/wstrb/addr/wdata` = the owner's fields. They are muxed to data-side fields when there is no owner.
- Address handshake:
  - Owner's `addr_ok` = `sram_req & sram_addr_ok`. The non-owner's `addr_ok` is 0.
  - On this handshake, push the owner id into the FIFO.
- Lock:
  - Set `lock_valid` with `lock_owner` = owner when `sram_req & !sram_addr_ok`.
  - Clear it on `sram_req & sram_addr_ok`.
  - A locked grant never switches masters, even if the other master has higher priority.
- Response routing:
  - On `sram_data_ok` with `count != 0`: pop the FIFO head and assert `data_ok` only to the head owner. The other master's `data_ok` is 0.
  - `sram_data_ok` with `count == 0` is a protocol error. It is ignored: no pop, no `data_ok` asserted to either master.
  - `inst_sram_rdata` and `data_sram_rdata` both equal `sram_rdata`. They are meaningful only with their `data_ok`.
- FIFO:
  - Push and pop in the same cycle leave `count` unchanged and are legal when full.
  - Pointers wrap modulo `DEPTH`.
  - Full blocks `sram_req` but does not change `lock_valid`.
- Starvation counter:
  - Increments by 1 each cycle `inst_sram_req & !inst_sram_addr_ok`, saturating at `STARVE_LIMIT`.
  - Clears to 0 on `inst_sram_addr_ok` or when `inst_sram_req` = 0.
- A master may hold its req across cycles. Its bundle must stay stable until its `addr_ok`.

## Timing
- Reset (`reset` = 0, asynchronous):
  - `lock_valid` = 0, `count` = 0, FIFO pointers = 0, `starve_cnt` = 0.
  - `sram_req`, both `addr_ok`, and both `data_ok` are forced to 0 while reset is asserted.
- Reset mid-operation discards outstanding entries. Late `sram_data_ok` beats after reset fall under the `count == 0` rule.
- Arbitration and address path: zero added latency. `addr_ok` reaches the master in the same cycle as `sram_addr_ok`.
- Response path: zero added latency. `data_ok` is returned in the same cycle as `sram_data_ok`.
- A FIFO push in cycle N is visible to routing from cycle N+1. The slave must not return `data_ok` for a request in the cycle of its own `addr_ok`; such a beat is routed against the prior head, or ignored if the FIFO is empty.
- Throughput: one accepted address per cycle while not full.
- Starvation: at most `STARVE_LIMIT` consecutive denied cycles plus the current locked transfer before inst is granted.

## Test plan
- Reset, then `inst_sram_req` alone at addr 0x1FC0_0000, slave `addr_ok` immediately, `data_ok` 3 cycles later with rdata 0x2408_0001 -> `inst_sram_addr_ok` in the same cycle; `inst_sram_data_ok` with rdata 0x2408_0001 three cycles later; `data_sram_data_ok` stays 0.
- Both masters request in the same cycle, slave `addr_ok` held high -> data granted first; inst granted the next cycle. Responses returned in order D, I route `data_ok` to data then to inst.
- Data requests, slave withholds `addr_ok` 4 cycles while inst also requests -> `sram_addr`/fields stay on the data bundle all 4 cycles; lock clears on the accepting cycle.
- `DEPTH`=2: three accepted-ready requests with no `data_ok` -> the third is held with `sram_req` = 0. A `data_ok` in the same cycle as the next push keeps `count` = 2.
- Data requests continuously and inst requests with `STARVE_LIMIT`=8 -> inst is granted on the 9th cycle; `starve_cnt` returns to 0.
- `sram_data_ok` with an empty FIFO -> no `data_ok` to either master, `count` stays 0. Assert `reset` low with 2 outstanding -> `count` = 0 and `sram_req` = 0 immediately.
